pcie_us_rq_tag_alloc: RTL



---
 rtl/pcie_us_rq_tag_alloc.sv | 119 +++++++++++
 1 files changed

// File: rtl/pcie_us_rq_tag_alloc.sv
// Requester tag allocator: offers the lowest free tag through a valid/ready
// handshake and reclaims tags from several release channels per cycle.
module pcie_us_rq_tag_alloc #(
  parameter int unsigned TAG_WIDTH     = 6,
  parameter int unsigned TAG_COUNT     = 2**TAG_WIDTH,
  parameter int unsigned RELEASE_PORTS = 2
) (
  input  logic                                 user_clk,
  input  logic                                 user_reset,
  output logic [TAG_WIDTH-1:0]                 m_axis_tag,
  output logic                                 m_axis_tag_valid,
  input  logic                                 m_axis_tag_ready,
  input  logic [RELEASE_PORTS*TAG_WIDTH-1:0]   s_release_tag,
  input  logic [RELEASE_PORTS-1:0]             s_release_valid,
  output logic [TAG_WIDTH:0]                   free_count,
  output logic [1:0]                           tag_av,
  output logic [RELEASE_PORTS-1:0]             err_release
);

  // Bitmap spans the full tag space so any tag value indexes it safely;
  // bits at or above TAG_COUNT are never set.
  localparam int unsigned POOL = 1 << TAG_WIDTH;
  localparam int unsigned CW   = TAG_WIDTH + 1;
  localparam logic [1:0]  AV_RST = (TAG_COUNT >= 3) ? 2'd3 : 2'(TAG_COUNT);

  logic [POOL-1:0]          used_q;
  logic [POOL-1:0]          used_d;
  logic [POOL-1:0]          rel_clr;
  logic [POOL-1:0]          fill_set;
  logic [TAG_WIDTH-1:0]     rel_tag [RELEASE_PORTS];
  logic [RELEASE_PORTS-1:0] rel_ok;
  logic                     rel_dup;
  logic [CW-1:0]            rel_cnt;
  logic [CW-1:0]            free_d;
  logic [1:0]               tag_av_d;
  logic                     hs;
  logic                     load;
  logic                     fill_found;
  logic [TAG_WIDTH-1:0]     fill_tag;
  logic [TAG_WIDTH-1:0]     tag_d;
  logic                     valid_d;

  assign hs   = m_axis_tag_valid && m_axis_tag_ready;
  assign load = !m_axis_tag_valid || hs;

  // Lowest clear bit of the bitmap as seen at the start of the cycle.
  always_comb begin
    fill_found = 1'b0;
    fill_tag   = '0;
    for (int i = int'(TAG_COUNT) - 1; i >= 0; i--) begin
      if (!used_q[i]) begin
        fill_found = 1'b1;
        fill_tag   = TAG_WIDTH'(i);
      end
    end
  end

  // Release qualification; lower-numbered ports win duplicate tags.
  always_comb begin
    rel_ok  = '0;
    rel_clr = '0;
    rel_cnt = '0;
    rel_dup = 1'b0;
    for (int p = 0; p < int'(RELEASE_PORTS); p++) begin
      rel_tag[p] = s_release_tag[p*TAG_WIDTH +: TAG_WIDTH];
    end
    for (int p = 0; p < int'(RELEASE_PORTS); p++) begin
      rel_dup = 1'b0;
      for (int q = 0; q < p; q++) begin
        if (s_release_valid[q] && (rel_tag[q] == rel_tag[p])) rel_dup = 1'b1;
      end
      rel_ok[p] = s_release_valid[p]
               && (CW'(rel_tag[p]) < CW'(TAG_COUNT))
               && used_q[rel_tag[p]]
               && !(m_axis_tag_valid && (rel_tag[p] == m_axis_tag))
               && !rel_dup;
      if (rel_ok[p]) begin
        rel_clr[rel_tag[p]] = 1'b1;
        rel_cnt             = rel_cnt + CW'(1);
      end
    end
  end

  // Next-state for bitmap, offer register and counters.
  always_comb begin
    fill_set = '0;
    tag_d    = m_axis_tag;
    valid_d  = m_axis_tag_valid;
    if (load) begin
      valid_d = fill_found;
      if (fill_found) begin
        tag_d              = fill_tag;
        fill_set[fill_tag] = 1'b1;
      end
    end
    used_d   = (used_q & ~rel_clr) | fill_set;
    free_d   = free_count + rel_cnt - CW'(hs);
    tag_av_d = (free_d >= CW'(3)) ? 2'd3 : free_d[1:0];
  end

  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      used_q           <= '0;
      m_axis_tag       <= '0;
      m_axis_tag_valid <= 1'b0;
      free_count       <= CW'(TAG_COUNT);
      tag_av           <= AV_RST;
      err_release      <= '0;
    end else begin
      used_q           <= used_d;
      m_axis_tag       <= tag_d;
      m_axis_tag_valid <= valid_d;
      free_count       <= free_d;
      tag_av           <= tag_av_d;
      err_release      <= s_release_valid & ~rel_ok;
    end
  end

endmodule
